func_preimage_search: RTL and testbench

- Sequential driver/checker for the team's combinational scrambler blocks, which map a narrow input code to a wide output word.
- It drives candidate input codes into such a block, samples the returned output and compares it against a requested target word.
- It reports the first input code that produces the target, and optionally the total number of codes that do. Used for inversion and coverage sweeps of the scrambler designs.

---
 rtl/func_preimage_search_if.sv | 31 +++
 rtl/func_preimage_search.sv | 113 +++++++++++
 tb/tb_func_preimage_search.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/func_preimage_search_if.sv
// Purpose: groups the search request, the candidate/result loop to the function block, and the result outputs.
// Latency: none; this is wiring only.
// Backpressure: none; start is a single-cycle request that the searcher ignores while it is busy.
interface func_preimage_search_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 12
);
    logic             start;
    logic             find_all;
    logic             abort;
    logic [OUT_W-1:0] target;
    logic [IN_W-1:0]  func_in;
    logic [OUT_W-1:0] func_out;
    logic             busy;
    logic             done;
    logic             found;
    logic [IN_W-1:0]  first_code;
    logic [IN_W:0]    match_count;

    // Requester side. It also models the function block, which returns func_out.
    modport master (
        output start, find_all, abort, target, func_out,
        input  func_in, busy, done, found, first_code, match_count
    );

    // Searcher side.
    modport slave (
        input  start, find_all, abort, target, func_out,
        output func_in, busy, done, found, first_code, match_count
    );
endinterface

// File: rtl/func_preimage_search.sv
// Purpose: sweeps input codes into a combinational scrambler and reports which codes map to a target word.
// Latency: each candidate costs SETTLE_CYCLES+1 cycles; a full sweep costs 2**IN_W*(SETTLE_CYCLES+1) cycles, then one DONE cycle.
// Backpressure: start is ignored while busy; abort cancels an active sweep without a done pulse.
module func_preimage_search #(
    parameter int IN_W          = 4,
    parameter int OUT_W         = 12,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    func_preimage_search_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // The counter is 4 bits wide because SETTLE_CYCLES never exceeds 15.
    localparam logic [3:0]      SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [IN_W-1:0] LAST_CODE     = '1;

    state_t           state;
    logic [3:0]       settle_cnt;
    logic [OUT_W-1:0] target_q;
    logic             find_all_q;
    logic             hit;

    // The match is exact across the full output width. It is only acted on in COMPARE.
    assign hit = (bus.func_out == target_q);

    // Search FSM. It keeps the candidate code, the handshake outputs and the accumulated results in registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            settle_cnt      <= '0;
            target_q        <= '0;
            find_all_q      <= 1'b0;
            bus.func_in     <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.found       <= 1'b0;
            bus.first_code  <= '0;
            bus.match_count <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    // abort is meaningless here, so start always wins a collision.
                    if (bus.start) begin
                        target_q        <= bus.target;
                        find_all_q      <= bus.find_all;
                        bus.found       <= 1'b0;
                        bus.first_code  <= '0;
                        bus.match_count <= '0;
                        bus.func_in     <= '0;
                        settle_cnt      <= SETTLE_RELOAD;
                        bus.busy        <= 1'b1;
                        state           <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (bus.abort) begin
                        bus.busy        <= 1'b0;
                        bus.found       <= 1'b0;
                        bus.first_code  <= '0;
                        bus.match_count <= '0;
                        state           <= IDLE;
                    end else if (settle_cnt == 4'd0) begin
                        state <= COMPARE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                COMPARE: begin
                    if (bus.abort) begin
                        bus.busy        <= 1'b0;
                        bus.found       <= 1'b0;
                        bus.first_code  <= '0;
                        bus.match_count <= '0;
                        state           <= IDLE;
                    end else begin
                        if (hit) begin
                            bus.match_count <= bus.match_count + 1'b1;
                            if (bus.match_count == '0) begin
                                bus.first_code <= bus.func_in;
                                bus.found      <= 1'b1;
                            end
                        end
                        // The sweep ends at the top code; func_in never wraps back to 0.
                        if ((hit && !find_all_q) || (bus.func_in == LAST_CODE)) begin
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            bus.func_in <= bus.func_in + 1'b1;
                            settle_cnt  <= SETTLE_RELOAD;
                            state       <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    // done is high for exactly this cycle. A late abort or start is ignored here.
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_func_preimage_search.sv
// Purpose: directed bench for func_preimage_search with a cycle-level reference model and hand-computed checks.
// Latency: the model predicts the outputs after every edge of dut1; dut3 has a long settle time and is checked by trace.
// Backpressure: covers start while busy, abort mid-sweep, a start/abort collision and reset mid-search.
module tb_func_preimage_search;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   stub_mode = 0;
    int   cyc;
    int   guard;

    always #5 clk = ~clk;

    func_preimage_search_if #(.IN_W(4), .OUT_W(12)) io1 ();
    func_preimage_search_if #(.IN_W(4), .OUT_W(12)) io3 ();

    func_preimage_search #(.IN_W(4), .OUT_W(12), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(io1)
    );
    func_preimage_search #(.IN_W(4), .OUT_W(12), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .bus(io3)
    );

    // Scrambler stubs. Mode 0 computes x*3 and mode 1 computes {x[3:1],0}.
    function automatic logic [11:0] stub(input int mode, input logic [3:0] x);
        if (mode == 1) return {8'h00, x[3:1], 1'b0};
        return 12'(x) * 12'd3;
    endfunction

    // dut1 sees a combinational stub.
    always_comb io1.func_out = stub(stub_mode, io1.func_in);

    // dut3 sees a stub that responds one cycle late.
    always @(posedge clk) io3.func_out <= stub(0, io3.func_in);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for dut1, which has SETTLE_CYCLES=1.
    // k counts the cycles since busy rose. Candidate c is compared at the end of slot c.
    localparam int S1 = 1;
    logic        m_busy  = 1'b0;
    logic        m_found = 1'b0;
    logic        m_fa    = 1'b0;
    logic [3:0]  m_fin   = '0;
    logic [3:0]  m_first = '0;
    logic [4:0]  m_cnt   = '0;
    logic [11:0] m_tgt   = '0;
    int          m_k = 0, m_end = 0, m_last = 0, m_mode = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy = 1'b0; m_k = 0; m_fin = '0;
                m_found = 1'b0; m_first = '0; m_cnt = '0;
            end else if (!m_busy) begin
                if (io1.start === 1'b1) begin
                    m_busy = 1'b1; m_k = 0;
                    m_tgt = io1.target; m_fa = io1.find_all; m_mode = stub_mode;
                    m_last = 15;
                    if (!m_fa)
                        for (int c = 15; c >= 0; c--)
                            if (stub(m_mode, 4'(c)) == m_tgt) m_last = c;
                    m_end = (m_last + 1) * (S1 + 1);
                    m_fin = '0; m_found = 1'b0; m_first = '0; m_cnt = '0;
                end
            end else if (io1.abort === 1'b1 && m_k < m_end) begin
                m_busy = 1'b0; m_found = 1'b0; m_first = '0; m_cnt = '0;
            end else begin
                m_k++;
                if (m_k > m_end) begin
                    m_busy = 1'b0;
                end else begin
                    int ncmp;
                    ncmp = m_k / (S1 + 1);
                    if (ncmp > m_last + 1) ncmp = m_last + 1;
                    m_fin = 4'((ncmp > m_last) ? m_last : ncmp);
                    m_found = 1'b0; m_first = '0; m_cnt = '0;
                    for (int c = 0; c < ncmp; c++)
                        if (stub(m_mode, 4'(c)) == m_tgt) begin
                            if (!m_found) m_first = 4'(c);
                            m_found = 1'b1;
                            m_cnt++;
                        end
                end
            end
        end
    end

    // Compare dut1 against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("m_busy",        io1.busy,        m_busy);
            chk("m_done",        io1.done,        (m_busy && m_k == m_end));
            chk("m_func_in",     io1.func_in,     m_fin);
            chk("m_found",       io1.found,       m_found);
            chk("m_first_code",  io1.first_code,  m_first);
            chk("m_match_count", io1.match_count, m_cnt);
        end
    end

    task automatic start1(input logic [11:0] t, input logic fa, input int mode);
        @(posedge clk); #1;
        stub_mode = mode; io1.target = t; io1.find_all = fa; io1.start = 1'b1;
        @(posedge clk); #1;
        io1.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (io1.done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_results(input string tag, input logic f, input logic [3:0] fc, input logic [4:0] mc);
        chk({tag, "_found"}, io1.found, f);
        chk({tag, "_first_code"}, io1.first_code, fc);
        chk({tag, "_match_count"}, io1.match_count, mc);
    endtask

    initial begin
        io1.start = 1'b0; io1.abort = 1'b0; io1.find_all = 1'b0; io1.target = '0;
        io3.start = 1'b0; io3.abort = 1'b0; io3.find_all = 1'b0; io3.target = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        chk("rst_busy", io1.busy, 0);
        chk("rst_func_in", io1.func_in, 0);
        chk_results("rst", 1'b0, 4'd0, 5'd0);

        // First-match search for x*3 == 0x015 should stop at candidate 7.
        start1(12'h015, 1'b0, 0);
        wait_done(cyc);
        chk("s1_latency", cyc, 16);
        chk_results("s1", 1'b1, 4'd7, 5'd1);
        @(posedge clk); #1;
        chk("s1_busy_low", io1.busy, 0);

        // Full sweep with two matches (codes 4 and 5).
        start1(12'h004, 1'b1, 1);
        wait_done(cyc);
        chk("s2_latency", cyc, 32);
        chk_results("s2", 1'b1, 4'd4, 5'd2);

        // Full sweep with no match. func_in must stop at 15.
        start1(12'hFFF, 1'b1, 0);
        wait_done(cyc);
        chk("s3_latency", cyc, 32);
        chk("s3_func_in", io1.func_in, 15);
        chk_results("s3", 1'b0, 4'd0, 5'd0);

        // SETTLE_CYCLES=3 with a registered stub. Each candidate is held for 4 cycles.
        @(posedge clk); #1;
        io3.target = 12'h009; io3.find_all = 1'b0; io3.start = 1'b1;
        @(posedge clk); #1;
        io3.start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("s4_hold", io3.func_in, k / 4);
            chk("s4_no_done", io3.done, 0);
            @(posedge clk); #1;
        end
        chk("s4_done", io3.done, 1);
        chk("s4_found", io3.found, 1);
        chk("s4_first_code", io3.first_code, 3);
        chk("s4_match_count", io3.match_count, 1);

        // Abort at candidate 5 after code 4 has already matched.
        start1(12'h004, 1'b1, 1);
        guard = 0;
        while (io1.func_in !== 4'd5 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("s5_reach5", io1.func_in, 5);
        chk("s5_found_pre", io1.found, 1);
        io1.abort = 1'b1;
        @(posedge clk); #1;
        io1.abort = 1'b0;
        chk("s5_abort_busy", io1.busy, 0);
        chk("s5_abort_done", io1.done, 0);
        chk_results("s5_abort", 1'b0, 4'd0, 5'd0);
        repeat (3) @(posedge clk);

        // A start while busy must not restart the search or change the latched target.
        start1(12'h015, 1'b0, 0);
        @(posedge clk); #1;
        io1.target = 12'hFFF; io1.find_all = 1'b1; io1.start = 1'b1;
        @(posedge clk); #1;
        io1.start = 1'b0;
        wait_done(cyc);
        chk("s5_ignored_latency", cyc, 14);
        chk_results("s5_ignored", 1'b1, 4'd7, 5'd1);

        // When start and abort arrive together in IDLE, start wins.
        @(posedge clk); #1;
        stub_mode = 0; io1.target = 12'h015; io1.find_all = 1'b0;
        io1.start = 1'b1; io1.abort = 1'b1;
        @(posedge clk); #1;
        io1.start = 1'b0; io1.abort = 1'b0;
        chk("s5_collide_busy", io1.busy, 1);
        wait_done(cyc);
        chk("s5_collide_latency", cyc, 16);
        chk_results("s5_collide", 1'b1, 4'd7, 5'd1);

        // Asynchronous reset during SETTLE of candidate 9.
        start1(12'hFFF, 1'b1, 0);
        guard = 0;
        while (io1.func_in !== 4'd9 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("s6_reach9", io1.func_in, 9);
        #2 rst = 1'b1;
        #1;
        chk("s6_rst_busy", io1.busy, 0);
        chk("s6_rst_done", io1.done, 0);
        chk("s6_rst_func_in", io1.func_in, 0);
        chk_results("s6_rst", 1'b0, 4'd0, 5'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        start1(12'h015, 1'b0, 0);
        chk("s6_restart_func_in", io1.func_in, 0);
        wait_done(cyc);
        chk("s6_restart_latency", cyc, 16);
        chk_results("s6_restart", 1'b1, 4'd7, 5'd1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
